synapse_integrator: RTL and testbench
=====================================

# synapse_integrator

Upstream stage of the LIF neuron: converts up to N_IN presynaptic spike lines into the 8-bit input current the neuron integrates. On each neuron enable tick it decays a signed synaptic accumulator, serially adds the programmable signed weight of every input that spiked, and publishes the clamped result as a registered current. Its tick is the same divided strobe that enables the neuron, so the current is stable before the neuron's next update.

## Interface
- N_IN, 8: number of presynaptic inputs (power of two, 2..16)
- W_WIDTH, 8: signed weight width
- ACC_WIDTH, 12: signed accumulator width
- DECAY_SHIFT, 2: decay per tick is acc >>> DECAY_SHIFT
- clk  in  1  clock; one clock domain; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- en  in  1  one-cycle tick strobe from the clock divider
- spike_in  in  N_IN  presynaptic spike levels, sampled on an accepted tick
- w_we  in  1  weight write enable
- w_addr  in  $clog2(N_IN)  weight index
- w_data  in  W_WIDTH  signed weight value
- current  out  8  unsigned current to the neuron, clamp(acc, 0, 255)
- valid  out  1  one-cycle pulse when current has been updated
- busy  out  1  high while a tick is being processed
- overrun  out  1  sticky: a tick arrived while busy

## Operation
- FSM: IDLE -> DECAY (1 cycle) -> ADD (N_IN cycles, index 0..N_IN-1) -> OUT (1 cycle) -> IDLE.
- IDLE: when en=1, capture spike_in into spk_q and go to DECAY.
- DECAY: acc <= acc - (acc >>> DECAY_SHIFT). The shift is arithmetic. Small positive residues persist (e.g. 3 stays 3). Small negatives reach 0 (-1 -> 0).
- ADD at index i: if spk_q[i], acc <= sat(acc + sext(weight[i])). Saturation limits are +2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1) (2047 / -2048), applied on every add.
- OUT: current <= 0 if acc<0, 255 if acc>255, else acc[7:0]. Then valid <= 1 for the next cycle only.
- en while busy is dropped, not queued, and sets overrun. overrun stays set until rst.
- Weight writes apply at the rising edge and are allowed in any state. During ADD, a write to the index being read in the same cycle is not seen: the old weight is used.
- Reset (async, at any time, including mid-ADD): state IDLE, acc 0, spk_q 0, all weights 0, current 0, valid 0, busy 0, overrun 0.

## Timing
- Tick accepted in cycle 0 (en=1, IDLE).
- busy is high in cycles 1..N_IN+2.
- DECAY runs in cycle 1, ADD in cycles 2..N_IN+1, OUT in cycle N_IN+2.
- The new current and valid=1 appear in cycle N_IN+3 (cycle 11 for N_IN=8). The state is IDLE again in that cycle, so en in cycle N_IN+3 is accepted.
- current holds its value between updates. It never glitches, because it is a register.
- All outputs are registered, with no combinational input-to-output path.
- The minimum tick spacing without overrun is N_IN+3 cycles. The divider period is far larger.

## Structure
- Package synapse_pkg holds:
  - the state enum (IDLE, DECAY, ADD, OUT);
  - ACC_MAX/ACC_MIN localparams derived from ACC_WIDTH;
  - a sat_add function;
  - a clamp_u8 function.
- Sub-module synapse_weight_rf is an N_IN x W_WIDTH register file. It has one synchronous write port (w_we/w_addr/w_data), one combinational read port indexed by the ADD counter, and async reset to 0.
- Top level: FSM, index counter, spk_q, acc, output registers.

## Test plan
- Reset: assert rst mid-simulation. Required: current=0, valid=0, busy=0, overrun=0 immediately. After release, a tick with all spikes gives current=0 (weights cleared).
- Basic sum: w0=20, w3=30, spike_in=8'b0000_1001, en in cycle 0. Required: busy high for cycles 1..10, valid pulse in cycle 11, current=50. Next tick with spike_in=0 gives current=38 (50-12).
- Inhibition: from acc=38, w1=-100, spike_in=8'b0000_0010, tick. Required: acc=29-100=-71, current=0. Next idle tick gives acc=-71-(-18)=-53, current=0.
- Saturation: all weights 127, spike_in=8'hFF on consecutive ticks.
  - Tick 1: acc=1016, current=255.
  - Tick 2: 1016-254=762, then +1016=1778.
  - Tick 3: 1778-444=1334, adds saturate at 2047, never wrap; current=255.
- Overrun: en in cycle 0 and again in cycle 4. Required: a single valid in cycle 11, result equal to a single tick, overrun=1 and still 1 after later clean ticks.
- Reset during ADD (cycle 5). Required: busy=0 and current=0 at once, no valid pulse, and the next tick behaves as the first after reset.

Source files
------------

// File: rtl/synapse_pkg.sv
// Shared types and arithmetic helpers for the synapse integrator.
// Pure combinational helpers; no state, no flow control.
package synapse_pkg;

    typedef enum logic [1:0] {IDLE, DECAY, ADD, OUT} state_t;

    localparam int ACC_WIDTH_DEF = 12;
    localparam int ACC_MAX = (2 ** (ACC_WIDTH_DEF - 1)) - 1;
    localparam int ACC_MIN = -(2 ** (ACC_WIDTH_DEF - 1));

    // Limits are derived from the caller's width so non-default accumulators saturate correctly.
    function automatic int sat_add(input int a, input int b, input int width);
        int hi;
        int lo;
        int s;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        s  = a + b;
        if (s > hi) begin
            s = hi;
        end else if (s < lo) begin
            s = lo;
        end
        return s;
    endfunction

    function automatic logic [7:0] clamp_u8(input int a);
        logic [7:0] r;
        if (a < 0) begin
            r = 8'd0;
        end else if (a > 255) begin
            r = 8'd255;
        end else begin
            r = a[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// N_IN x W_WIDTH weight register file: synchronous write, combinational read.
// Writes land on the clock edge, so a same-cycle read returns the old weight; never stalls.
module synapse_weight_rf #(
    parameter int N_IN    = 8,
    parameter int W_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_we,
    input  logic [$clog2(N_IN)-1:0] w_addr,
    input  logic [W_WIDTH-1:0]      w_data,
    input  logic [$clog2(N_IN)-1:0] rd_addr,
    output logic [W_WIDTH-1:0]      rd_data
);
    import synapse_pkg::*;

    logic [W_WIDTH-1:0] w_q [N_IN];
    logic [W_WIDTH-1:0] w_d [N_IN];

    always_comb begin
        w_d = w_q;
        if (w_we) begin
            w_d[w_addr] = w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '{default: '0};
        end else begin
            w_q <= w_d;
        end
    end

    assign rd_data = w_q[rd_addr];

endmodule

// File: rtl/synapse_integrator.sv
// Per tick: decay the signed accumulator, serially add weights of spiking inputs, publish clamp(acc,0,255).
// Result N_IN+3 cycles after the tick; ticks arriving while busy are dropped and flagged in sticky overrun.
module synapse_integrator #(
    parameter int N_IN        = 8,
    parameter int W_WIDTH     = 8,
    parameter int ACC_WIDTH   = 12,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    w_we,
    input  logic [$clog2(N_IN)-1:0] w_addr,
    input  logic [W_WIDTH-1:0]      w_data,
    output logic [7:0]              current,
    output logic                    valid,
    output logic                    busy,
    output logic                    overrun
);
    import synapse_pkg::*;

    localparam int IW = $clog2(N_IN);

    state_t                       state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [N_IN-1:0]              spk_q, spk_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [7:0]                   current_q, current_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         overrun_q, overrun_d;
    logic [W_WIDTH-1:0]           w_rd;

    synapse_weight_rf #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH)
    ) u_weight_rf (
        .clk     (clk),
        .rst     (rst),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .rd_addr (idx_q),
        .rd_data (w_rd)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        spk_d     = spk_q;
        acc_d     = acc_q;
        current_d = current_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        if (en && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (en) begin
                    spk_d   = spike_in;
                    state_d = DECAY;
                end
            end
            DECAY: begin
                // Arithmetic shift: small negatives round toward -inf and decay to 0.
                acc_d   = acc_q - (acc_q >>> DECAY_SHIFT);
                idx_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                if (spk_q[idx_q]) begin
                    acc_d = ACC_WIDTH'(sat_add(int'(acc_q), int'($signed(w_rd)), ACC_WIDTH));
                end
                if (idx_q == IW'(N_IN - 1)) begin
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            OUT: begin
                current_d = clamp_u8(int'(acc_q));
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            spk_q     <= '0;
            acc_q     <= '0;
            current_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            spk_q     <= spk_d;
            acc_q     <= acc_d;
            current_q <= current_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign current = current_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_synapse_integrator.sv
// Scoreboarded bench for synapse_integrator: a behavioural model predicts each tick's current.
module tb_synapse_integrator;
    localparam int N_IN = 8;
    localparam int LAT  = N_IN + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] spike_in = '0;
    logic       w_we = 1'b0;
    logic [2:0] w_addr = '0;
    logic [7:0] w_data = '0;
    logic [7:0] current;
    logic       valid;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int model_acc = 0;
    int model_w[N_IN];

    always #5 clk = ~clk;

    synapse_integrator #(
        .N_IN(8), .W_WIDTH(8), .ACC_WIDTH(12), .DECAY_SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .current(current), .valid(valid), .busy(busy), .overrun(overrun)
    );

    task automatic model_reset();
        model_acc = 0;
        for (int i = 0; i < N_IN; i++) model_w[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_tick(input logic [7:0] spk, output int cur);
        model_acc = model_acc - (model_acc >>> 2);
        for (int i = 0; i < N_IN; i++) begin
            if (spk[i]) begin
                model_acc = model_acc + model_w[i];
                if (model_acc > 2047) model_acc = 2047;
                if (model_acc < -2048) model_acc = -2048;
            end
        end
        cur = (model_acc < 0) ? 0 : ((model_acc > 255) ? 255 : model_acc);
    endtask

    task automatic write_w(input int idx, input int val);
        @(posedge clk); #1;
        w_we = 1'b1; w_addr = 3'(idx); w_data = 8'(val);
        @(posedge clk); #1;
        w_we = 1'b0;
        model_w[idx] = val;
    endtask

    // Drives one tick, then waits (bounded) for valid and checks latency, busy window and value.
    task automatic tick(input logic [7:0] spk, input string name);
        int cur;
        int exp_cur;
        int busy_bad;
        bit seen;
        model_tick(spk, cur);
        exp_q.push_back(cur);
        busy_bad = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        spike_in = spk; en = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                en = 1'b0;
                spike_in = 8'($urandom);
            end
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                exp_cur = exp_q.pop_front();
                checks++;
                if (c !== LAT) begin
                    errors++;
                    $display("FAIL %s latency: got %0d required %0d", name, c, LAT);
                end
                checks++;
                if (int'(current) !== exp_cur) begin
                    errors++;
                    $display("FAIL %s current: got %0d required %0d", name, current, exp_cur);
                end
                checks++;
                if (busy !== 1'b0 || busy_bad != 0) begin
                    errors++;
                    $display("FAIL %s busy window: busy_at_valid=%b low_cycles_before=%0d required 0/0",
                             name, busy, busy_bad);
                end
                break;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        if (!seen) begin
            checks++; errors++;
            void'(exp_q.pop_front());
            $display("FAIL %s timeout: no valid within 40 cycles, required one at cycle %0d", name, LAT);
        end else begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL %s valid width: got valid=%b one cycle later, required 0", name, valid);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({current, valid, busy, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset outputs: got current=%0d valid=%b busy=%b overrun=%b required all 0",
                     current, valid, busy, overrun);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        tick(8'hFF, "reset_first_tick");
    endtask

    task automatic test_basic();
        write_w(0, 20);
        write_w(3, 30);
        tick(8'b0000_1001, "basic_sum");
        tick(8'h00, "basic_decay");
    endtask

    task automatic test_inhibition();
        write_w(1, -100);
        tick(8'b0000_0010, "inhibit");
        tick(8'h00, "inhibit_decay");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N_IN; i++) write_w(i, 127);
        tick(8'hFF, "sat_t1");
        tick(8'hFF, "sat_t2");
        tick(8'hFF, "sat_t3");
        // Decaying from the clamped value exposes any wrap at 2047.
        for (int k = 0; k < 8; k++) tick(8'h00, "sat_decay");
    endtask

    task automatic test_overrun();
        int cur;
        int exp_cur;
        int n_valid;
        int first_c;
        int got_cur;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b required 0", overrun);
        end
        model_tick(8'h00, cur);
        exp_q.push_back(cur);
        n_valid = 0; first_c = -1; got_cur = -1;
        @(posedge clk); #1;
        spike_in = 8'h00; en = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            en = (c == 4);
            spike_in = (c == 4) ? 8'hFF : 8'h00;
            @(negedge clk);
            if (valid) begin
                n_valid++;
                if (first_c < 0) begin
                    first_c = c;
                    got_cur = int'(current);
                end
            end
        end
        exp_cur = exp_q.pop_front();
        checks++;
        if (n_valid != 1 || first_c != LAT) begin
            errors++;
            $display("FAIL overrun_valid: got %0d pulses first at %0d required 1 at %0d", n_valid, first_c, LAT);
        end
        checks++;
        if (got_cur !== exp_cur) begin
            errors++;
            $display("FAIL overrun_current: got %0d required %0d", got_cur, exp_cur);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        tick(8'h00, "overrun_clean");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
    endtask

    task automatic test_reset_mid_add();
        int n_valid;
        write_w(2, 40);
        @(posedge clk); #1;
        spike_in = 8'hFF; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({current, valid, busy, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_add outputs: got current=%0d valid=%b busy=%b overrun=%b required all 0",
                     current, valid, busy, overrun);
        end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        n_valid = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid) n_valid++;
        end
        checks++;
        if (n_valid != 0) begin
            errors++;
            $display("FAIL reset_mid_add no_valid: got %0d pulses required 0", n_valid);
        end
        tick(8'hFF, "after_reset_cleared");
        write_w(2, 40);
        tick(8'b0000_0100, "after_reset_fresh");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_inhibition();
        test_saturation();
        test_overrun();
        test_reset_mid_add();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
